// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared definitions for the display scan controller.
//   scan_state_e : scan FSM state encoding
//   SEL_OFF_*    : all-digits-off select values for each polarity
//   apply_pol    : maps an active-high logical pattern to pin polarity
package scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      ON    = 2'd2
   } scan_state_e;

   localparam logic [7:0] SEL_OFF_LOW  = 8'hFF;
   localparam logic [7:0] SEL_OFF_HIGH = 8'h00;

   function automatic logic [7:0] apply_pol(input logic [7:0] v, input bit active_low);
      return active_low ? ~v : v;
   endfunction

endpackage

// File: rtl/decoder_scan_ctrl_decoder.sv
// 3-to-8 binary decoder, purely combinational.
//   a     : binary index in
//   bcode : one-hot, active-high out (bit a set)
module binary_decoder_3x8 (
   input  logic [2:0] a,
   output logic [7:0] bcode
);

   always_comb begin
      bcode    = '0;
      bcode[a] = 1'b1;
   end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit LED display.
// Walks a digit index 0..7, inserting BLANK_CYCLES all-off cycles before
// each visit and driving the digit for ON_CYCLES when enabled in digit_mask.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : scan enable; dropping it parks the FSM with outputs off
//   digit_mask  : bit i enables digit i (sampled at the end of its blank)
//   data_in     : segment pattern per digit, active-high logical
//   sel         : one-hot digit select, polarity per SEL_ACTIVE_LOW
//   seg         : segment drive, polarity per SEG_ACTIVE_LOW
//   idx         : current digit index
//   frame_tick  : one-cycle pulse after idx wraps 7->0
module decoder_scan_ctrl
   import scan_pkg::*;
#(
   parameter int unsigned ON_CYCLES      = 4,
   parameter int unsigned BLANK_CYCLES   = 2,
   parameter bit          SEL_ACTIVE_LOW = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [7:0]  digit_mask,
   input  logic [63:0] data_in,
   output logic [7:0]  sel,
   output logic [7:0]  seg,
   output logic [2:0]  idx,
   output logic        frame_tick
);

   localparam int unsigned MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
   localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

   localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   localparam logic [7:0] SEL_OFF = SEL_ACTIVE_LOW ? SEL_OFF_LOW : SEL_OFF_HIGH;
   localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? SEL_OFF_LOW : SEL_OFF_HIGH;

   scan_state_e   state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    idx_q;
   logic [7:0]    sel_q;
   logic [7:0]    seg_q;
   logic          frame_tick_q;

   logic [7:0]    dec_onehot;
   logic [7:0]    seg_raw;
   logic [2:0]    idx_d;
   logic          wrap;

   binary_decoder_3x8 u_dec (
      .a     (idx_q),
      .bcode (dec_onehot)
   );

   always_comb begin
      seg_raw = data_in[{idx_q, 3'b000} +: 8];
      idx_d   = idx_q + 3'd1;
      wrap    = (idx_q == 3'd7);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         sel_q        <= SEL_OFF;
         seg_q        <= SEG_OFF;
         frame_tick_q <= 1'b0;
      end else begin
         frame_tick_q <= 1'b0;
         if (!en) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= SEL_OFF;
            seg_q   <= SEG_OFF;
         end else begin
            unique case (state_q)
               IDLE: begin
                  state_q <= BLANK;
                  cnt_q   <= '0;
                  sel_q   <= SEL_OFF;
                  seg_q   <= SEG_OFF;
               end
               BLANK: begin
                  sel_q <= SEL_OFF;
                  seg_q <= SEG_OFF;
                  if (cnt_q == BLANK_LAST) begin
                     cnt_q <= '0;
                     if (digit_mask[idx_q]) begin
                        // Drive the digit on the same edge the FSM enters ON so
                        // sel/seg are valid for exactly ON_CYCLES cycles.
                        state_q <= ON;
                        sel_q   <= apply_pol(dec_onehot, SEL_ACTIVE_LOW);
                        seg_q   <= apply_pol(seg_raw, SEG_ACTIVE_LOW);
                     end else begin
                        // Masked digit: advance without lighting, stay blank.
                        idx_q        <= idx_d;
                        frame_tick_q <= wrap;
                     end
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               ON: begin
                  if (cnt_q == ON_LAST) begin
                     state_q      <= BLANK;
                     cnt_q        <= '0;
                     idx_q        <= idx_d;
                     frame_tick_q <= wrap;
                     sel_q        <= SEL_OFF;
                     seg_q        <= SEG_OFF;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                     sel_q <= apply_pol(dec_onehot, SEL_ACTIVE_LOW);
                     seg_q <= apply_pol(seg_raw, SEG_ACTIVE_LOW);
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  sel_q   <= SEL_OFF;
                  seg_q   <= SEG_OFF;
               end
            endcase
         end
      end
   end

   assign sel        = sel_q;
   assign seg        = seg_q;
   assign idx        = idx_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
module tb_decoder_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [7:0]  digit_mask;
   logic [63:0] data_in;

   logic [7:0]  sel_a, seg_a, sel_b, seg_b;
   logic [2:0]  idx_a, idx_b;
   logic        ft_a, ft_b;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   bit          chk_on = 1'b0;

   always #5 clk = ~clk;

   // Instance A: default timing, active-low pins.
   decoder_scan_ctrl u_a (
      .clk(clk), .rst_n(rst_n), .en(en), .digit_mask(digit_mask), .data_in(data_in),
      .sel(sel_a), .seg(seg_a), .idx(idx_a), .frame_tick(ft_a)
   );

   // Instance B: short timing, active-high pins.
   decoder_scan_ctrl #(
      .ON_CYCLES(3), .BLANK_CYCLES(1), .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .en(en), .digit_mask(digit_mask), .data_in(data_in),
      .sel(sel_b), .seg(seg_b), .idx(idx_b), .frame_tick(ft_b)
   );

   // Reference model: each digit visit is a span of time t = 0.. ;
   // the digit is lit while t >= B, the visit ends at t == B (masked)
   // or t == B + ON (lit).
   typedef struct {
      bit          run;
      int unsigned t;
      bit          lit;
      logic [2:0]  idx;
      logic [7:0]  sel;
      logic [7:0]  seg;
      bit          ft;
   } ms_t;

   function automatic ms_t m_reset(input bit sal, input bit gal);
      ms_t n;
      n.run = 0; n.t = 0; n.lit = 0; n.idx = 3'd0; n.ft = 0;
      n.sel = sal ? 8'hFF : 8'h00;
      n.seg = gal ? 8'hFF : 8'h00;
      return n;
   endfunction

   function automatic ms_t m_step(input ms_t s, input bit e, input logic [7:0] m,
                                  input logic [63:0] d, input int unsigned B,
                                  input int unsigned ON, input bit sal, input bit gal);
      ms_t n = s;
      bit on;
      logic [7:0] one, pat;
      n.ft = 0;
      if (!e) begin
         n.run = 0;
      end else if (!s.run) begin
         n.run = 1; n.t = 0; n.lit = 0;
      end else begin
         n.t = s.t + 1;
         if (n.t == B) n.lit = m[s.idx];
         if ((n.t == B && !n.lit) || (n.t == B + ON)) begin
            n.idx = s.idx + 3'd1;
            n.ft  = (s.idx == 3'd7);
            n.t   = 0;
            n.lit = 0;
         end
      end
      on  = n.run && (n.t >= B);
      one = 8'd1 << n.idx;
      pat = d[n.idx*8 +: 8];
      if (!on) begin one = 8'h00; pat = 8'h00; end
      n.sel = sal ? ~one : one;
      n.seg = gal ? ~pat : pat;
      return n;
   endfunction

   ms_t ma = m_reset(1'b1, 1'b1);
   ms_t mb = m_reset(1'b0, 1'b0);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma = m_reset(1'b1, 1'b1);
         mb = m_reset(1'b0, 1'b0);
      end else begin
         ma = m_step(ma, en, digit_mask, data_in, 2, 4, 1'b1, 1'b1);
         mb = m_step(mb, en, digit_mask, data_in, 1, 3, 1'b0, 1'b0);
      end
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("A.sel", sel_a, ma.sel);
         chk("A.seg", seg_a, ma.seg);
         chk("A.idx", {5'd0, idx_a}, {5'd0, ma.idx});
         chk("A.tick", {7'd0, ft_a}, {7'd0, ma.ft});
         chk("B.sel", sel_b, mb.sel);
         chk("B.seg", seg_b, mb.seg);
         chk("B.idx", {5'd0, idx_b}, {5'd0, mb.idx});
         chk("B.tick", {7'd0, ft_b}, {7'd0, mb.ft});
      end
   end

   task automatic cyc(input int unsigned n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst_n = 1'b0;
      en = 1'b0;
      cyc(2);
      rst_n = 1'b1;
   endtask

   // Measures frame_tick spacing for both instances over a window.
   task automatic run_period(input string nm, input int unsigned ncyc,
                             input int unsigned exp_a, input int unsigned exp_b);
      int last_a = -1, last_b = -1;
      int gaps_a = 0, gaps_b = 0;
      for (int c = 0; c < int'(ncyc); c++) begin
         cyc(1);
         if (ft_a) begin
            if (last_a >= 0) begin
               chk({nm, ".periodA"}, 8'(c - last_a), 8'(exp_a));
               gaps_a++;
            end
            last_a = c;
         end
         if (ft_b) begin
            if (last_b >= 0) begin
               chk({nm, ".periodB"}, 8'(c - last_b), 8'(exp_b));
               gaps_b++;
            end
            last_b = c;
         end
      end
      chk({nm, ".gapsA_seen"}, 8'(gaps_a > 0), 8'd1);
      chk({nm, ".gapsB_seen"}, 8'(gaps_b > 0), 8'd1);
   endtask

   task automatic wait_a(input string nm, input logic [2:0] want_idx, input logic [7:0] want_sel);
      int unsigned k = 0;
      while (!(idx_a == want_idx && sel_a == want_sel) && k < 300) begin
         cyc(1);
         k++;
      end
      chk({nm, ".reached"}, 8'(k < 300), 8'd1);
   endtask

   logic [63:0] ramp;

   initial begin
      rst_n      = 1'b0;
      en         = 1'b0;
      digit_mask = 8'hFF;
      for (int i = 0; i < 8; i++) ramp[i*8 +: 8] = 8'h10 + 8'(i);
      data_in    = ramp;
      cyc(2);
      chk_on = 1'b1;
      chk("rst.A.sel", sel_a, 8'hFF);
      chk("rst.A.seg", seg_a, 8'hFF);
      chk("rst.B.sel", sel_b, 8'h00);
      chk("rst.A.tick", {7'd0, ft_a}, 8'd0);
      rst_n = 1'b1;
      cyc(1);

      // Basic scan, literal timeline for instance A.
      en = 1'b1;
      cyc(1); chk("tl.blank0", sel_a, 8'hFF);
      cyc(1); chk("tl.blank1", sel_a, 8'hFF);
      cyc(1); chk("tl.on0.sel", sel_a, 8'hFE); chk("tl.on0.seg", seg_a, 8'hEF);
      cyc(3); chk("tl.on3.sel", sel_a, 8'hFE);
      cyc(1); chk("tl.blank_d1", sel_a, 8'hFF); chk("tl.idx1", {5'd0, idx_a}, 8'd1);
      cyc(1); chk("tl.blank_d1b", sel_a, 8'hFF);
      cyc(1); chk("tl.on1.sel", sel_a, 8'hFD); chk("tl.on1.seg", seg_a, 8'hEE);

      run_period("full", 130, 48, 32);
      digit_mask = 8'b0000_0101;
      run_period("m05", 80, 24, 14);
      digit_mask = 8'h00;
      run_period("m00", 50, 16, 8);

      // Enable dropped during the ON slot of digit 3.
      do_reset();
      digit_mask = 8'hFF;
      en = 1'b1;
      wait_a("en3", 3'd3, 8'hF7);
      en = 1'b0;
      cyc(1);
      chk("en3.sel_off", sel_a, 8'hFF);
      chk("en3.seg_off", seg_a, 8'hFF);
      chk("en3.idx_hold", {5'd0, idx_a}, 8'd3);
      cyc(2);
      chk("en3.idle_idx", {5'd0, idx_a}, 8'd3);
      en = 1'b1;
      cyc(1); chk("en3.blank0", sel_a, 8'hFF);
      cyc(1); chk("en3.blank1", sel_a, 8'hFF);
      for (int i = 0; i < 4; i++) begin
         cyc(1); chk("en3.slot", sel_a, 8'hF7);
      end
      cyc(1); chk("en3.after", sel_a, 8'hFF);

      // Asynchronous reset mid-ON of digit 5.
      wait_a("rst5", 3'd5, 8'hDF);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst5.sel", sel_a, 8'hFF);
      chk("rst5.seg", seg_a, 8'hFF);
      chk("rst5.idx", {5'd0, idx_a}, 8'd0);
      chk("rst5.B.sel", sel_b, 8'h00);
      #1 rst_n = 1'b1;
      cyc(2); chk("rst5.restart_blank", sel_a, 8'hFF);
      cyc(1); chk("rst5.restart_d0", sel_a, 8'hFE);

      // Active-high instance, digit 6 pattern A5.
      data_in[6*8 +: 8] = 8'hA5;
      begin
         int unsigned k = 0;
         while (!(idx_b == 3'd6 && sel_b != 8'h00) && k < 300) begin
            cyc(1);
            k++;
         end
         chk("pol.reached", 8'(k < 300), 8'd1);
         chk("pol.sel", sel_b, 8'h40);
         chk("pol.seg", seg_b, 8'hA5);
         k = 0;
         while (sel_b != 8'h00 && k < 10) begin
            cyc(1);
            k++;
         end
         chk("pol.off", sel_b, 8'h00);
         chk("pol.segoff", seg_b, 8'h00);
      end

      // Randomized traffic checked by the model.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         #1;
         en = ($urandom_range(0, 24) != 0);
         if ($urandom_range(0, 39) == 0) digit_mask = 8'($urandom);
         if ($urandom_range(0, 3) == 0) data_in = {$urandom, $urandom};
         if ($urandom_range(0, 299) == 0) begin
            #1 rst_n = 1'b0;
            #1;
            chk("rnd.rst.sel", sel_a, 8'hFF);
            chk("rnd.rst.idx", {5'd0, idx_a}, 8'd0);
            #1 rst_n = 1'b1;
         end
      end

      cyc(2);
      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/decoder_scan_ctrl.md
Name: decoder_scan_ctrl

Overview:
- Time-multiplexed scan controller for an 8-digit common-anode/common-cathode display.
- Sequences a 3-bit digit index through 0..7 and drives it into an internal binary_decoder_3x8 instance to produce a one-hot digit select.
- Inserts a blanking gap between digits to suppress ghosting and skips digits disabled by a mask.
- Sits between the display register file and the board's digit/segment pins.

Parameters:
- ON_CYCLES, 4, clock cycles a digit is driven per visit; must be >= 1.
- BLANK_CYCLES, 2, clock cycles with all digits off before each visit; must be >= 1.
- SEL_ACTIVE_LOW, 1, 1: sel asserted-low (off = 8'hFF); 0: asserted-high (off = 8'h00).
- SEG_ACTIVE_LOW, 1, same convention for seg.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable
- digit_mask  in  8  bit i = 1 enables digit i
- data_in  in  64  segment patterns, digit i = data_in[8i+7:8i], active-high logical (bit=1 lights segment)
- sel  out  8  one-hot digit select, polarity per SEL_ACTIVE_LOW
- seg  out  8  segment drive, polarity per SEG_ACTIVE_LOW
- idx  out  3  current digit index
- frame_tick  out  1  one-cycle pulse on idx wrap 7->0

Behaviour:
- All outputs are registered.
- Reset (async, rst_n=0):
  - state=IDLE, idx=0, cycle counter=0.
  - sel=off, seg=off, frame_tick=0.
  - Reset asserted mid-scan forces these values immediately; no partial slot completes.
- FSM states IDLE, BLANK, ON:
  - IDLE: sel/seg off. en=1 -> BLANK with counter=0, idx unchanged.
  - BLANK: sel/seg off; counter increments each cycle. When counter==BLANK_CYCLES-1:
    - digit_mask[idx]=1 -> ON, counter=0.
    - digit_mask[idx]=0 -> skip: idx advances, stay BLANK, counter=0.
  - ON: sel=decoder(idx) with polarity applied; seg=data_in slice for idx with polarity applied, sampled every cycle (live update). When counter==ON_CYCLES-1: idx advances, -> BLANK, counter=0.
- en=0 in any state -> IDLE at the next edge.
  - Outputs go off on that edge; idx holds its value.
  - Re-enabling resumes from BLANK at the held idx.
- idx advance:
  - idx wraps 7->0 (3-bit modulo).
  - frame_tick=1 for exactly the cycle following any 7->0 advance, whether from ON or from a skip.
- Mask boundaries:
  - digit_mask=8'h00: FSM cycles BLANK only; sel never asserts; frame_tick every 8*BLANK_CYCLES cycles.
  - digit_mask sampled only at the end of BLANK. A change during ON takes effect at the next visit.
- Full-frame period with all digits enabled: 8*(BLANK_CYCLES+ON_CYCLES) cycles.
- sel is never asserted while idx is changing. Every idx change is followed by at least BLANK_CYCLES all-off cycles.
- Counter width: $clog2 of max(ON_CYCLES, BLANK_CYCLES) + 1, unsigned, no overflow possible.
- Decoder is purely combinational inside; its output passes through the sel register, giving one-cycle latency from idx to sel.

Decomposition:
- Shared package scan_pkg:
  - FSM state encoding (IDLE=2'd0, BLANK=2'd1, ON=2'd2).
  - Constants SEL_OFF_LOW=8'hFF and SEL_OFF_HIGH=8'h00.
- One sub-module: existing binary_decoder_3x8 (a[2:0] -> bcode[7:0]), instantiated once and fed by idx.
- Polarity inversion and registers stay in decoder_scan_ctrl.

Test Plan:
- Reset, then en=1, mask=8'hFF, defaults (ON=4, BLANK=2), data_in digit i = 8'h10+i:
  - sel=8'hFF for 2 cycles, then 8'hFE for 4 cycles with seg=~8'h10.
  - then 2 off cycles, then 8'hFD with seg=~8'h11.
  - frame_tick pulses once every 48 cycles.
- mask=8'b0000_0101: only sel=8'hFE and 8'hFB ever appear; digits 1,3..7 consume 2 blank cycles each; frame period 2*6+6*2=24 cycles.
- mask=8'h00: sel stays 8'hFF indefinitely; frame_tick every 16 cycles; idx visits 0..7.
- en dropped during ON of digit 3:
  - next edge sel=8'hFF, seg=8'hFF, idx=3 held.
  - re-enable -> 2 blank cycles, then digit 3 gets a full 4-cycle ON slot.
- rst_n pulsed low mid-ON of digit 5: outputs off and idx=0 without waiting for clk; after release with en=1, scan restarts at digit 0.
- SEL_ACTIVE_LOW=0, SEG_ACTIVE_LOW=0, idx=6, data=8'hA5: sel=8'h40, seg=8'hA5; off value 8'h00 during blank.
